// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and helpers for the registered ALU.
// Optional multiplier is controlled by the ALU_SEQ_MUL_EN macro.
package alu_seq_pkg;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;
    localparam logic [OPW-1:0] OP_XOR = 4'd4;
    localparam logic [OPW-1:0] OP_NOT = 4'd5;
    localparam logic [OPW-1:0] OP_INC = 4'd6;
    localparam logic [OPW-1:0] OP_DEC = 4'd7;
    localparam logic [OPW-1:0] OP_ADC = 4'd8;
    localparam logic [OPW-1:0] OP_SBB = 4'd9;
    localparam logic [OPW-1:0] OP_SHL = 4'd10;
    localparam logic [OPW-1:0] OP_SHR = 4'd11;
    localparam logic [OPW-1:0] OP_SAR = 4'd12;
    localparam logic [OPW-1:0] OP_MUL = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Single-cycle ops whose CarryOut is latched into creg; MUL is handled at its done.
    function automatic logic updatesCarry(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_SBB,
            OP_SHL, OP_SHR, OP_SAR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/alu_seq_mul.sv
// WIDTH-cycle shift-add unsigned multiplier; done is asserted during the last step,
// with product carrying that step's final value so the caller can register it on the same edge.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand, acc, accNext;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    assign accNext = mplier[0] ? acc + mcand : acc;
    assign done    = busy && (cnt == CW'(1));
    assign product = accNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, persistent carry and optional
// multi-cycle multiply (enabled by defining ALU_SEQ_MUL_EN; otherwise OP 13 is illegal).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             ZeroFlag,
    output logic             NegFlag,
    output logic             OvfFlag,
    output logic             IllegalOp
);
    localparam logic [WIDTH-1:0] WMOD = WIDTH'(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cy;
        logic             ovf;
        logic             ill;
    } aluResp_t;

    state_e   state, stateNext;
    aluResp_t alu;
    logic     creg, accept, isMul, mulDone;

    logic [WIDTH:0]           sum, diff;
    logic [WIDTH-1:0]         amt;
    logic [2*WIDTH-1:0]       shlWide, shrWide;
    logic signed [2*WIDTH-1:0] sarWide;

    assign in_ready  = (state == ST_IDLE) || (state == ST_RESP && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_RESP);
    assign ZeroFlag  = (Result == '0);
    assign NegFlag   = Result[WIDTH-1];
    assign amt       = B % WMOD;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mulProd;

    assign isMul = (OP == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) uMul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && isMul),
        .a       (A),
        .b       (B),
        .done    (mulDone),
        .product (mulProd)
    );
`else
    assign isMul   = 1'b0;
    assign mulDone = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (accept) stateNext = isMul ? ST_MUL : ST_RESP;
            ST_MUL:  if (mulDone) stateNext = ST_RESP;
            ST_RESP: if (out_ready) stateNext = accept ? (isMul ? ST_MUL : ST_RESP) : ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Arithmetic at WIDTH+1 bits: bit WIDTH is carry for adds and borrow for subtracts.
    always_comb begin
        alu     = '0;
        sum     = '0;
        diff    = '0;
        shlWide = '0;
        shrWide = '0;
        sarWide = '0;
        case (OP)
            OP_ADD, OP_ADC: begin
                sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (OP == OP_ADC) && creg};
                alu.res = sum[WIDTH-1:0];
                alu.cy  = sum[WIDTH];
                alu.ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                diff    = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, (OP == OP_SBB) && creg};
                alu.res = diff[WIDTH-1:0];
                alu.cy  = diff[WIDTH];
                alu.ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_INC: begin
                sum     = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
                alu.res = sum[WIDTH-1:0];
                alu.cy  = sum[WIDTH];
                alu.ovf = !A[WIDTH-1] && sum[WIDTH-1];
            end
            OP_DEC: begin
                diff    = {1'b0, A} - {{WIDTH{1'b0}}, 1'b1};
                alu.res = diff[WIDTH-1:0];
                alu.cy  = diff[WIDTH];
                alu.ovf = A[WIDTH-1] && !diff[WIDTH-1];
            end
            OP_AND: alu.res = A & B;
            OP_OR:  alu.res = A | B;
            OP_XOR: alu.res = A ^ B;
            OP_NOT: alu.res = ~A;
            // Shifts run in a double-width window so the last bit out lands next to the result.
            OP_SHL: begin
                shlWide = {{WIDTH{1'b0}}, A} << amt;
                alu.res = shlWide[WIDTH-1:0];
                alu.cy  = (amt != '0) && shlWide[WIDTH];
            end
            OP_SHR: begin
                shrWide = {A, {WIDTH{1'b0}}} >> amt;
                alu.res = shrWide[2*WIDTH-1:WIDTH];
                alu.cy  = shrWide[WIDTH-1];
            end
            OP_SAR: begin
                sarWide = $signed({A, {WIDTH{1'b0}}}) >>> amt;
                alu.res = sarWide[2*WIDTH-1:WIDTH];
                alu.cy  = sarWide[WIDTH-1];
            end
            default: alu.ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result    <= '0;
            CarryOut  <= 1'b0;
            OvfFlag   <= 1'b0;
            IllegalOp <= 1'b0;
            creg      <= 1'b0;
        end else if (accept && !isMul) begin
            Result    <= alu.res;
            CarryOut  <= alu.cy;
            OvfFlag   <= alu.ovf;
            IllegalOp <= alu.ill;
            if (updatesCarry(OP)) creg <= alu.cy;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (mulDone) begin
            Result    <= mulProd[WIDTH-1:0];
            CarryOut  <= |mulProd[2*WIDTH-1:WIDTH];
            OvfFlag   <= |mulProd[2*WIDTH-1:WIDTH];
            IllegalOp <= 1'b0;
            creg      <= |mulProd[2*WIDTH-1:WIDTH];
        end
`endif
    end
endmodule
